// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative shift-add multiply / restoring divide with HI/LO results
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_b_zero;
    logic [WIDTH-1:0]   r_a_orig;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     r_rem;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    logic               w_accept;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH+1:0]   w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_remd;

    assign w_accept = (r_state == c_ST_IDLE) && start && !abort;
    assign w_sign_a = op[0] & a[WIDTH-1];
    assign w_sign_b = op[0] & b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? -a : a;
    assign w_mag_b  = w_sign_b ? -b : b;

    // Multiply: upper half accumulates, multiplier shifts out of the lower half.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);

    // Divide: dividend shifts out of r_acc[WIDTH-1:0], quotient bits shift in.
    assign w_div_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_div_ok    = !w_div_diff[WIDTH+1];

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quot = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_remd = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next_state = c_ST_CALC;
            c_ST_CALC: begin
                if (abort)                    w_next_state = c_ST_IDLE;
                else if (r_cnt == c_CNT_LAST) w_next_state = c_ST_FIX;
            end
            c_ST_FIX:  w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b_zero <= 1'b0;
            r_a_orig <= '0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt    <= c_CNT_INIT;
                r_is_div <= op[1];
                r_neg_q  <= w_sign_a ^ w_sign_b;
                r_neg_r  <= w_sign_a;
                r_b_zero <= (b == '0);
                r_a_orig <= a;
                r_rem    <= '0;
                if (op[1]) begin
                    r_opnd <= w_mag_b;
                    r_acc  <= {{WIDTH{1'b0}}, w_mag_a};
                end else begin
                    r_opnd <= w_mag_a;
                    r_acc  <= {{WIDTH{1'b0}}, w_mag_b};
                end
            end else if ((r_state == c_ST_CALC) && !abort) begin
                r_cnt <= r_cnt - c_CNT_LAST;
                if (r_is_div) begin
                    r_rem <= w_div_ok ? w_div_diff[WIDTH:0] : w_div_shift;
                    r_acc <= {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_div_ok};
                end else begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                end
            end else if ((r_state == c_ST_FIX) && !abort) begin
                r_done <= 1'b1;
                if (!r_is_div) begin
                    r_hi  <= w_prod[2*WIDTH-1:WIDTH];
                    r_lo  <= w_prod[WIDTH-1:0];
                    r_dbz <= 1'b0;
                end else if (r_b_zero) begin
                    r_hi  <= r_a_orig;
                    r_lo  <= '1;
                    r_dbz <= 1'b1;
                end else begin
                    r_hi  <= w_remd;
                    r_lo  <= w_quot;
                    r_dbz <= 1'b0;
                end
            end
        end
    end

    assign busy        = (r_state != c_ST_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

`default_nettype wire
